// File: rtl/loss_stream_accum_pkg.sv
// rtl/loss_stream_accum_pkg.sv - shared types, widths and output saturation for the loss accumulator
// Purpose: fixed-point format constants, mode/state enums and the
//          accumulator-to-output saturation helper used by every file of the block.
// Ports:   none (package).
package loss_pkg;

  localparam int IL    = 4;
  localparam int FL    = 16;
  localparam int LANES = 16;
  localparam int GUARD = 8;
  localparam int CNT_W = 16;

  localparam int DW    = IL + FL;
  localparam int ACC_W = IL + FL + GUARD + $clog2(LANES);
  localparam int NUM_W = $clog2(LANES + 1);

  typedef enum logic {LOSS_L2 = 1'b0, LOSS_L1 = 1'b1} loss_mode_t;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, HOLD} state_t;

  // Largest positive value representable in Q(IL.FL), zero-extended to ACC_W.
  localparam logic [ACC_W-1:0] DW_MAX = {{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}};

  // The accumulator only ever holds non-negative sums, so clipping is one-sided.
  function automatic logic [DW-1:0] sat_to_dw(input logic [ACC_W-1:0] acc);
    if (acc > DW_MAX) begin
      return {1'b0, {(DW-1){1'b1}}};
    end
    return acc[DW-1:0];
  endfunction

endpackage

// File: rtl/loss_stream_accum_if.sv
// rtl/loss_stream_accum_if.sv - input beat stream and frame result channel of the loss accumulator
// Purpose: bundles the beat handshake (mode, in_valid/in_ready, in_last, num,
//          yHat, y) and the result handshake (out_valid/out_ready, sum, count, sat).
// Modports: master = beat producer / result consumer, slave = loss_stream_accum.
interface loss_stream_accum_if;
  import loss_pkg::*;

  logic                      mode;
  logic                      in_valid;
  logic                      in_ready;
  logic                      in_last;
  logic [NUM_W-1:0]          num;
  logic [LANES-1:0][DW-1:0]  yHat;
  logic [LANES-1:0][DW-1:0]  y;
  logic                      out_valid;
  logic                      out_ready;
  logic [DW-1:0]             sum;
  logic [CNT_W-1:0]          count;
  logic                      sat;

  modport master (
    output mode, in_valid, in_last, num, yHat, y, out_ready,
    input  in_ready, out_valid, sum, count, sat
  );

  modport slave (
    input  mode, in_valid, in_last, num, yHat, y, out_ready,
    output in_ready, out_valid, sum, count, sat
  );

endinterface

// File: rtl/loss_stream_accum_lane_term.sv
// rtl/loss_stream_accum_lane_term.sv - one lane of the loss pipeline: registered difference and its loss term
// Purpose: S1 registers d = yHat - y (zero when the lane is disabled);
//          S2 derives the non-negative term (d*d)>>>FL or |d| from that register.
// Ports:   clk, reset (async active-low), en_i lane enable for this beat,
//          yhat_i / y_i signed Q(IL.FL) inputs, mode_i frame mode,
//          term_o unsigned ACC_W-bit term (combinational from the S1 register).
module loss_lane_term
  import loss_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en_i,
  input  logic signed [DW-1:0] yhat_i,
  input  logic signed [DW-1:0] y_i,
  input  loss_mode_t           mode_i,
  output logic [ACC_W-1:0]     term_o
);

  logic signed [DW:0]      d_q;
  logic signed [2*DW+1:0]  d_ext;
  logic signed [2*DW+1:0]  sq;
  logic signed [2*DW+1:0]  sq_sh;
  logic [DW:0]             mag;
  logic [ACC_W-1:0]        sq_term;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      d_q <= '0;
    end else begin
      d_q <= en_i ? ({yhat_i[DW-1], yhat_i} - {y_i[DW-1], y_i}) : '0;
    end
  end

  // Square at full product width so the truncating shift sees the exact value.
  assign d_ext = {{(DW+1){d_q[DW]}}, d_q};
  assign sq    = d_ext * d_ext;
  assign sq_sh = sq >>> FL;
  assign mag   = d_q[DW] ? $unsigned(-d_q) : $unsigned(d_q);

  always_comb begin
    sq_term = sq_sh[ACC_W-1:0];
    // The largest square cannot reach ACC_W bits; clip anyway so the term never wraps.
    if (|sq_sh[2*DW+1:ACC_W]) begin
      sq_term = '1;
    end
    term_o = (mode_i == LOSS_L2) ? sq_term : ACC_W'(mag);
  end

endmodule

// File: rtl/loss_stream_accum.sv
// rtl/loss_stream_accum.sv - streaming L2/L1 loss accumulator over multi-beat frames
// Purpose: accepts LANES (yHat, y) pairs per beat, accumulates a saturating
//          loss sum across a frame and returns one Q(IL.FL) result per frame.
// Ports:   clk rising edge, reset async active-low,
//          bus (slave) beat input channel and frame result channel.
module loss_stream_accum
  import loss_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  loss_stream_accum_if.slave bus
);

  state_t            state_q;
  loss_mode_t        mode_q;
  logic              in_ready_q;
  logic              out_valid_q;
  logic [1:0]        drain_q;
  logic [DW-1:0]     sum_q;
  logic              sat_out_q;

  logic              s1_valid_q;
  logic              s2_valid_q;
  logic [ACC_W-1:0]  tree_q;
  logic [ACC_W-1:0]  acc_q;
  logic              sat_q;
  logic [CNT_W-1:0]  count_q;

  logic              accept;
  logic              release_hs;
  logic [NUM_W-1:0]  num_cl;
  logic [ACC_W-1:0]  terms [LANES];
  logic [ACC_W-1:0]  tree_d;
  logic [ACC_W:0]    acc_d;
  logic [CNT_W:0]    cnt_d;

  assign accept     = bus.in_valid && in_ready_q;
  assign release_hs = out_valid_q && bus.out_ready;
  assign num_cl     = (bus.num > NUM_W'(LANES)) ? NUM_W'(LANES) : bus.num;

  // The first beat's mode goes straight to its lanes: mode_q is only updated on
  // the accepting edge, and the lanes use mode_q one cycle later in S2.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    loss_lane_term u_lane (
      .clk    (clk),
      .reset  (reset),
      .en_i   (accept && (NUM_W'(g) < num_cl)),
      .yhat_i (bus.yHat[g]),
      .y_i    (bus.y[g]),
      .mode_i (mode_q),
      .term_o (terms[g])
    );
  end

  always_comb begin
    tree_d = '0;
    for (int i = 0; i < LANES; i++) begin
      tree_d = tree_d + terms[i];
    end
  end

  assign acc_d = {1'b0, acc_q} + {1'b0, tree_q};
  assign cnt_d = {1'b0, count_q} + (CNT_W+1)'(num_cl);

  // Pipeline, accumulator and element counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      tree_q     <= '0;
      acc_q      <= '0;
      sat_q      <= 1'b0;
      count_q    <= '0;
    end else begin
      s1_valid_q <= accept;
      s2_valid_q <= s1_valid_q;
      tree_q     <= tree_d;
      if (release_hs) begin
        acc_q   <= '0;
        sat_q   <= 1'b0;
        count_q <= '0;
      end else begin
        if (s2_valid_q) begin
          if (acc_d[ACC_W]) begin
            acc_q <= '1;
            sat_q <= 1'b1;
          end else begin
            acc_q <= acc_d[ACC_W-1:0];
          end
        end
        if (accept) begin
          count_q <= cnt_d[CNT_W] ? '1 : cnt_d[CNT_W-1:0];
        end
      end
    end
  end

  // Frame control. DRAIN lets the last beat pass S1..S3 before the result is latched.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mode_q      <= LOSS_L2;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      drain_q     <= '0;
      sum_q       <= '0;
      sat_out_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            mode_q <= loss_mode_t'(bus.mode);
            if (bus.in_last) begin
              state_q    <= DRAIN;
              in_ready_q <= 1'b0;
              drain_q    <= '0;
            end else begin
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          if (accept && bus.in_last) begin
            state_q    <= DRAIN;
            in_ready_q <= 1'b0;
            drain_q    <= '0;
          end
        end
        DRAIN: begin
          if (drain_q == 2'd2) begin
            state_q     <= HOLD;
            out_valid_q <= 1'b1;
            sum_q       <= sat_to_dw(acc_q);
            sat_out_q   <= sat_q || (acc_q > DW_MAX);
          end else begin
            drain_q <= drain_q + 2'd1;
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            sat_out_q   <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.sum       = sum_q;
  assign bus.count     = count_q;
  assign bus.sat       = sat_out_q;

endmodule

// File: tb/tb_loss_stream_accum.sv
// tb/tb_loss_stream_accum.sv - directed self-checking bench for loss_stream_accum
module tb_loss_stream_accum;
  import loss_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  loss_stream_accum_if bus ();

  loss_stream_accum dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    bus.mode      = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_last   = 1'b0;
    bus.num       = '0;
    bus.out_ready = 1'b0;
    for (int j = 0; j < LANES; j++) begin
      bus.yHat[j] = '0;
      bus.y[j]    = '0;
    end
  endtask

  // yHat[j] = j*0x1000, y[j] = 0x3000
  task automatic load_ramp();
    for (int j = 0; j < LANES; j++) begin
      bus.yHat[j] = DW'(j * 32'h1000);
      bus.y[j]    = DW'(32'h3000);
    end
  endtask

  // yHat[j] = j<<16, y[j] = 3<<16
  task automatic load_big();
    for (int j = 0; j < LANES; j++) begin
      bus.yHat[j] = DW'(j << 16);
      bus.y[j]    = DW'(3 << 16);
    end
  endtask

  // Called #1 after a rising edge; the beat is taken on the next rising edge.
  task automatic send_beat(input logic m, input logic last, input int n);
    bus.mode     = m;
    bus.in_last  = last;
    bus.num      = NUM_W'(n);
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  // Edges after the accepting edge until out_valid is seen; 0 on timeout.
  task automatic wait_out(output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", bus.in_ready); end
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.sum !== 20'h0) begin bad++; $display("FAIL reset_sum got=%h exp=0", bus.sum); end
    total++; if (bus.count !== 16'h0) begin bad++; $display("FAIL reset_count got=%h exp=0", bus.count); end
    total++; if (bus.sat !== 1'b0) begin bad++; $display("FAIL reset_sat got=%b exp=0", bus.sat); end
  endtask

  task automatic test_l1_single();
    int lat;
    load_ramp();
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL l1_ready got=%b exp=1", bus.in_ready); end
    send_beat(1'b1, 1'b1, 10);
    wait_out(lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL l1_latency got=%0d exp=3", lat); end
    total++; if (bus.sum !== 20'h1B000) begin bad++; $display("FAIL l1_sum got=%h exp=1b000", bus.sum); end
    total++; if (bus.count !== 16'd10) begin bad++; $display("FAIL l1_count got=%0d exp=10", bus.count); end
    total++; if (bus.sat !== 1'b0) begin bad++; $display("FAIL l1_sat got=%b exp=0", bus.sat); end
    total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL l1_hold_ready got=%b exp=0", bus.in_ready); end
    handshake();
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL l1_release_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL l1_release_ready got=%b exp=1", bus.in_ready); end
    total++; if (bus.sum !== 20'h1B000) begin bad++; $display("FAIL l1_sum_holds got=%h exp=1b000", bus.sum); end
    total++; if (bus.count !== 16'd0) begin bad++; $display("FAIL l1_count_clear got=%0d exp=0", bus.count); end
  endtask

  task automatic test_l2_single();
    int lat;
    load_ramp();
    send_beat(1'b0, 1'b1, 10);
    wait_out(lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL l2_latency got=%0d exp=3", lat); end
    total++; if (bus.sum !== 20'h06900) begin bad++; $display("FAIL l2_sum got=%h exp=06900", bus.sum); end
    total++; if (bus.count !== 16'd10) begin bad++; $display("FAIL l2_count got=%0d exp=10", bus.count); end
    total++; if (bus.sat !== 1'b0) begin bad++; $display("FAIL l2_sat got=%b exp=0", bus.sat); end
    handshake();
  endtask

  task automatic test_l2_saturate();
    int lat;
    load_big();
    send_beat(1'b0, 1'b1, 10);
    wait_out(lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL l2sat_latency got=%0d exp=3", lat); end
    total++; if (bus.sum !== 20'h7FFFF) begin bad++; $display("FAIL l2sat_sum got=%h exp=7ffff", bus.sum); end
    total++; if (bus.sat !== 1'b1) begin bad++; $display("FAIL l2sat_sat got=%b exp=1", bus.sat); end
    total++; if (bus.count !== 16'd10) begin bad++; $display("FAIL l2sat_count got=%0d exp=10", bus.count); end
    handshake();
    total++; if (bus.sat !== 1'b0) begin bad++; $display("FAIL l2sat_sat_clear got=%b exp=0", bus.sat); end
  endtask

  task automatic test_back_to_back();
    int lat;
    load_ramp();
    send_beat(1'b1, 1'b0, 10);
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL b2b_run_ready got=%b exp=1", bus.in_ready); end
    send_beat(1'b0, 1'b1, 10);
    wait_out(lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL b2b_latency got=%0d exp=3", lat); end
    total++; if (bus.sum !== 20'h36000) begin bad++; $display("FAIL b2b_sum got=%h exp=36000", bus.sum); end
    total++; if (bus.count !== 16'd20) begin bad++; $display("FAIL b2b_count got=%0d exp=20", bus.count); end
    total++; if (bus.sat !== 1'b0) begin bad++; $display("FAIL b2b_sat got=%b exp=0", bus.sat); end
    handshake();
  endtask

  task automatic test_hold_stall();
    int lat;
    load_ramp();
    send_beat(1'b1, 1'b0, 0);
    send_beat(1'b1, 1'b1, 20);
    wait_out(lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL stall_latency got=%0d exp=3", lat); end
    // An offered beat during HOLD must not be taken.
    bus.in_valid = 1'b1;
    bus.num      = NUM_W'(16);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL stall_valid[%0d] got=%b exp=1", i, bus.out_valid); end
      total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL stall_ready[%0d] got=%b exp=0", i, bus.in_ready); end
      total++; if (bus.sum !== 20'h54000) begin bad++; $display("FAIL stall_sum[%0d] got=%h exp=54000", i, bus.sum); end
      total++; if (bus.count !== 16'd16) begin bad++; $display("FAIL stall_count[%0d] got=%0d exp=16", i, bus.count); end
    end
    bus.in_valid = 1'b0;
    handshake();
    total++; if (bus.count !== 16'd0) begin bad++; $display("FAIL stall_count_clear got=%0d exp=0", bus.count); end
    send_beat(1'b1, 1'b1, 10);
    wait_out(lat);
    total++; if (bus.sum !== 20'h1B000) begin bad++; $display("FAIL stall_next_sum got=%h exp=1b000", bus.sum); end
    total++; if (bus.count !== 16'd10) begin bad++; $display("FAIL stall_next_count got=%0d exp=10", bus.count); end
    handshake();
  endtask

  task automatic test_reset_mid_frame();
    int lat;
    load_ramp();
    send_beat(1'b1, 1'b0, 10);
    reset = 1'b0;
    #1;
    total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rmid_valid got=%b exp=0", bus.out_valid); end
    total++; if (bus.sum !== 20'h0) begin bad++; $display("FAIL rmid_sum got=%h exp=0", bus.sum); end
    total++; if (bus.count !== 16'h0) begin bad++; $display("FAIL rmid_count got=%h exp=0", bus.count); end
    total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b exp=1", bus.in_ready); end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    send_beat(1'b1, 1'b1, 10);
    wait_out(lat);
    total++; if (lat !== 3) begin bad++; $display("FAIL rmid_latency got=%0d exp=3", lat); end
    total++; if (bus.sum !== 20'h1B000) begin bad++; $display("FAIL rmid_sum_after got=%h exp=1b000", bus.sum); end
    total++; if (bus.count !== 16'd10) begin bad++; $display("FAIL rmid_count_after got=%0d exp=10", bus.count); end
    handshake();
  endtask

  initial begin
    reset = 1'b0;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    test_l1_single();
    test_l2_single();
    test_l2_saturate();
    test_back_to_back();
    test_hold_stall();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
